target_port: RTL and testbench

- Bus-side target endpoint and the downstream consumer of the initiator port's serial stream.
- Deserializes a 16-bit address (mode 0) and, for writes, an 8-bit data byte (mode 1), both LSB first.
- Decodes the address against a base window, runs a valid/ready handshake with the local target memory or peripheral, and returns read data serially.
- Acknowledges each completed transfer with a one-cycle target_ack pulse.

---
 rtl/target_port.sv | 146 ++++++++++++++
 tb/tb_target_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/target_port.sv
// Serial bus target endpoint: deserializes address/write data, decodes a base
// window, handshakes with a local target and returns read data LSB first.
module target_port #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          ADDR_W    = 12,
    parameter int          TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_data_in,
    input  logic              bus_data_in_valid,
    input  logic              bus_mode,
    input  logic              bus_init_rw,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              target_ack,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic [7:0]        tgt_wdata,
    output logic              tgt_wr_en,
    output logic              tgt_rd_en,
    input  logic              tgt_ready,
    input  logic [7:0]        tgt_rdata,
    input  logic              tgt_rdata_valid
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WDATA, WR, RD_REQ, RD_WAIT, RSEND} state_t;

    state_t        state;
    logic [14:0]   addr;   // bit 15 only matters for the decode on the last address bit
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic [3:0]    cnt;
    logic [TW-1:0] tcnt;
    logic          win_hit;

    assign win_hit   = (({bus_data_in, addr} >> ADDR_W) == (BASE_ADDR >> ADDR_W));
    assign tgt_addr  = addr[ADDR_W-1:0];
    assign tgt_wdata = wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            addr               <= '0;
            wdata              <= '0;
            rdata              <= '0;
            cnt                <= '0;
            tcnt               <= '0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            target_ack         <= 1'b0;
            tgt_wr_en          <= 1'b0;
            tgt_rd_en          <= 1'b0;
        end else begin
            target_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_data_in_valid && !bus_mode) begin
                        if (cnt == 4'd15) begin
                            cnt <= '0;
                            if (win_hit) begin
                                if (bus_init_rw) begin
                                    state <= WDATA;
                                    tcnt  <= '0;
                                end else begin
                                    state     <= RD_REQ;
                                    tgt_rd_en <= 1'b1;
                                end
                            end
                        end else begin
                            addr[cnt] <= bus_data_in;
                            cnt       <= cnt + 4'd1;
                        end
                    end
                end
                WDATA: begin
                    if (bus_data_in_valid && bus_mode) begin
                        wdata[cnt[2:0]] <= bus_data_in;
                        tcnt            <= '0;
                        if (cnt == 4'd7) begin
                            cnt       <= '0;
                            state     <= WR;
                            tgt_wr_en <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (bus_data_in_valid) begin
                        // an address bit means the initiator restarted; keep it as bit 0
                        addr[0] <= bus_data_in;
                        cnt     <= 4'd1;
                        state   <= IDLE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        tcnt  <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WR: begin
                    if (tgt_ready) begin
                        tgt_wr_en  <= 1'b0;
                        target_ack <= 1'b1;
                        state      <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (tgt_ready) begin
                        tgt_rd_en <= 1'b0;
                        if (tgt_rdata_valid) begin
                            rdata              <= tgt_rdata;
                            bus_data_out       <= tgt_rdata[0];
                            bus_data_out_valid <= 1'b1;
                            cnt                <= 4'd1;
                            state              <= RSEND;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (tgt_rdata_valid) begin
                        rdata              <= tgt_rdata;
                        bus_data_out       <= tgt_rdata[0];
                        bus_data_out_valid <= 1'b1;
                        cnt                <= 4'd1;
                        state              <= RSEND;
                    end
                end
                RSEND: begin
                    if (cnt == 4'd8) begin
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        target_ack         <= 1'b1;
                        cnt                <= '0;
                        state              <= IDLE;
                    end else begin
                        bus_data_out <= rdata[cnt[2:0]];
                        cnt          <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_target_port.sv
// Randomized bench for target_port: bus-level stimulus, a responding target
// model and transaction-level expectations derived from the address window rule.
module tb_target_port;
    localparam logic [15:0] BASE = 16'h0000;
    localparam int          AW   = 12;
    localparam int          TO   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_data_in = 1'b0, bus_data_in_valid = 1'b0, bus_mode = 1'b0, bus_init_rw = 1'b0;
    logic          bus_data_out, bus_data_out_valid, target_ack;
    logic [AW-1:0] tgt_addr;
    logic [7:0]    tgt_wdata;
    logic          tgt_wr_en, tgt_rd_en;
    logic          tgt_ready = 1'b0;
    logic [7:0]    tgt_rdata = 8'h00;
    logic          tgt_rdata_valid = 1'b0;

    always #5 clk = ~clk;

    target_port #(.BASE_ADDR(BASE), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .bus_mode(bus_mode), .bus_init_rw(bus_init_rw),
        .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .target_ack(target_ack), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_wr_en(tgt_wr_en), .tgt_rd_en(tgt_rd_en), .tgt_ready(tgt_ready),
        .tgt_rdata(tgt_rdata), .tgt_rdata_valid(tgt_rdata_valid)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, viol = 0;
    int req_cyc = 0, rdv_cnt = 0, ready_dly = 0, rdv_dly = 0, rdv_cyc = 0, first_cyc = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0, p_addr = '0;
    logic [7:0]    wr_data = '0, p_wdata = '0;
    logic          p_en = 0, p_wr = 0, p_ready = 0, p_ack = 0, p_sv = 0, rd_pending = 0;
    bit            sq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [15:0] a);
        return (a >> AW) == (BASE >> AW);
    endfunction

    // One clock: observe the edge's results, then let the target model answer.
    task automatic step();
        logic en;
        @(posedge clk);
        #1;
        cyc++;
        en = tgt_wr_en | tgt_rd_en;
        if (tgt_wr_en && tgt_rd_en) viol++;
        if (!bus_data_out_valid && bus_data_out) viol++;
        if (p_en && p_ready) begin
            if (en) viol++;
            if (p_wr) begin
                wr_cnt++; wr_addr = p_addr; wr_data = p_wdata;
                if (!target_ack) viol++;
            end else begin
                rd_cnt++; rd_addr = p_addr;
                rd_pending = (rdv_dly != 0); rdv_cnt = 0;
            end
            req_cyc = 0;
        end else if (en && p_en) begin
            if (tgt_addr !== p_addr || tgt_wdata !== p_wdata || tgt_wr_en !== p_wr) viol++;
        end
        if (target_ack) begin
            ack_cnt++;
            if (bus_data_out_valid || en || p_ack) viol++;
        end
        if (bus_data_out_valid) begin
            sq.push_back(bus_data_out);
            if (!p_sv) first_cyc = cyc;
        end
        tgt_ready = 1'b0;
        tgt_rdata_valid = 1'b0;
        if (en) begin
            tgt_ready = (req_cyc >= ready_dly);
            req_cyc++;
            if (tgt_rd_en && tgt_ready && rdv_dly == 0) begin
                tgt_rdata_valid = 1'b1; rdv_cyc = cyc;
            end
        end else if (rd_pending) begin
            rdv_cnt++;
            if (rdv_cnt == rdv_dly) begin
                tgt_rdata_valid = 1'b1; rd_pending = 0; rdv_cyc = cyc;
            end
        end
        p_en = en; p_wr = tgt_wr_en; p_ready = tgt_ready; p_addr = tgt_addr;
        p_wdata = tgt_wdata; p_ack = target_ack; p_sv = bus_data_out_valid;
    endtask

    task automatic drive(input logic v, input logic b, input logic m, input logic rw);
        bus_data_in_valid = v; bus_data_in = b; bus_mode = m; bus_init_rw = rw;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw, input bit noise);
        int g;
        for (int i = 0; i < 16; i++) begin
            g = noise ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                if ($urandom_range(0, 1) == 1)
                    drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
                else
                    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            end
            drive(1'b1, a[i], 1'b0, (i == 15) ? rw : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_data(input logic [7:0] d, input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps) idle($urandom_range(0, TO - 2));
            drive(1'b1, d[i], 1'b1, 1'b0);
        end
    endtask

    task automatic wait_ack(input int k0);
        int n;
        n = 0;
        while (ack_cnt == k0 && n < 80) begin idle(1); n++; end
    endtask

    task automatic txn(input logic [15:0] a, input logic rw, input logic [7:0] d,
                       input int rdy, input int rdv, input bit noise);
        bit h;
        int w0, r0, k0, s0;
        logic [7:0] sb;
        h = is_hit(a);
        w0 = wr_cnt; r0 = rd_cnt; k0 = ack_cnt; s0 = sq.size();
        ready_dly = rdy; rdv_dly = rdv; tgt_rdata = d;
        send_addr(a, rw, noise);
        if (!rw) chk("rd_lat", 32'(tgt_rd_en), 32'(h));
        if (rw) begin
            send_data(d, 0, 8, 1);
            if (h) chk("wr_lat", 32'(tgt_wr_en), 1);
        end
        if (h) wait_ack(k0);
        idle(3);
        chk("wr_cnt", 32'(wr_cnt - w0), 32'(h && rw));
        chk("rd_cnt", 32'(rd_cnt - r0), 32'(h && !rw));
        chk("ack_cnt", 32'(ack_cnt - k0), 32'(h));
        if (h && rw) begin
            chk("wr_addr", 32'(wr_addr), 32'(a[AW-1:0]));
            chk("wr_data", 32'(wr_data), 32'(d));
        end
        if (h && !rw) begin
            chk("rd_addr", 32'(rd_addr), 32'(a[AW-1:0]));
            chk("rd_nbits", 32'(sq.size() - s0), 8);
            sb = '0;
            if (sq.size() >= s0 + 8)
                for (int i = 0; i < 8; i++) sb[i] = sq[s0 + i];
            chk("rd_byte", 32'(sb), 32'(d));
            chk("rd_lat2", 32'(first_cyc - rdv_cyc), 1);
        end else begin
            chk("no_serial", 32'(sq.size() - s0), 0);
        end
        chk("protocol", 32'(viol), 0);
    endtask

    // Three data bits, an idle gap, then the rest: the write survives only if gap < TO.
    task automatic tmo(input logic [15:0] a, input logic [7:0] d, input int gap);
        int w0, k0;
        w0 = wr_cnt; k0 = ack_cnt; ready_dly = 0;
        send_addr(a, 1'b1, 0);
        send_data(d, 0, 3, 0);
        idle(gap);
        send_data(d, 3, 8, 0);
        wait_ack(k0);
        idle(2);
        chk("tmo_wr", 32'(wr_cnt - w0), 32'(gap < TO));
        chk("tmo_ack", 32'(ack_cnt - k0), 32'(gap < TO));
        if (gap < TO) chk("tmo_data", 32'(wr_data), 32'(d));
    endtask

    initial begin
        int k0, s0, n, w0;
        logic [7:0] rv;
        logic [15:0] a;
        rst_n = 1'b0;
        idle(3);
        chk("rst_out", 32'({bus_data_out, bus_data_out_valid, target_ack, tgt_wr_en,
                            tgt_rd_en, tgt_addr, tgt_wdata}), 0);
        rst_n = 1'b1;
        idle(2);

        txn(16'h0123, 1'b1, 8'hA5, 0, 0, 0);
        txn(16'h0456, 1'b0, 8'h3C, 3, 2, 0);
        txn(16'h1456, 1'b0, 8'h77, 0, 0, 0);
        txn(16'h1456, 1'b1, 8'h77, 0, 0, 0);
        txn(16'h0456, 1'b0, 8'hC3, 0, 0, 0);
        tmo(16'h0234, 8'h5A, TO);
        tmo(16'h0234, 8'h96, TO - 1);
        txn(16'h0234, 1'b1, 8'h69, 0, 0, 1);
        txn(16'h0FFF, 1'b1, 8'hE1, 5, 0, 1);

        // write aborted by a fresh read address
        w0 = wr_cnt;
        send_addr(16'h0321, 1'b1, 0);
        send_data(8'hFF, 0, 3, 0);
        txn(16'h0ABC, 1'b0, 8'h81, 1, 1, 0);
        chk("abort_nowr", 32'(wr_cnt - w0), 0);

        // reset while the fifth read bit is on the wire
        k0 = ack_cnt; s0 = sq.size(); ready_dly = 1; rdv_dly = 1;
        rv = 8'($urandom); tgt_rdata = rv;
        send_addr(16'h0456, 1'b0, 1);
        n = 0;
        while (sq.size() - s0 < 5 && n < 60) begin idle(1); n++; end
        chk("rst_reach", 32'(sq.size() - s0), 5);
        rst_n = 1'b0;
        idle(1);
        chk("rst_mid", 32'({bus_data_out, bus_data_out_valid, target_ack, tgt_wr_en,
                            tgt_rd_en, tgt_addr, tgt_wdata}), 0);
        chk("rst_noack", 32'(ack_cnt - k0), 0);
        rst_n = 1'b1;
        rd_pending = 0; req_cyc = 0; tgt_ready = 0; tgt_rdata_valid = 0;
        p_en = 0; p_ready = 0; p_sv = 0;
        idle(1);
        txn(16'h0456, 1'b0, ~rv, 2, 1, 1);

        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
            txn(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
